// File: rtl/subchannel_router_fifo.sv
// Routes an input beat stream into per-subchannel FIFOs (round-robin slices or ganged full-width),
// with a drain-before-mode-switch FSM, level reporting and a sticky/saturating error tracker.
module subchannel_router_fifo #(
  parameter int NUM_SUBCHANNELS  = 2,
  parameter int SUBCHANNEL_WIDTH = 40,
  parameter int FIFO_DEPTH       = 8,
  parameter int ERR_CNT_WIDTH    = 8,
  localparam int DATA_WIDTH      = NUM_SUBCHANNELS*SUBCHANNEL_WIDTH,
  localparam int LVL_W           = $clog2(FIFO_DEPTH+1)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             cfg_ganged,
  input  logic [NUM_SUBCHANNELS-1:0]       cfg_subchannel_en,
  input  logic [DATA_WIDTH-1:0]            data_in,
  input  logic                             data_in_valid,
  output logic                             data_in_ready,
  output logic [DATA_WIDTH-1:0]            subch_data_out,
  output logic [NUM_SUBCHANNELS-1:0]       subch_valid,
  input  logic [NUM_SUBCHANNELS-1:0]       subch_ready,
  output logic [NUM_SUBCHANNELS*LVL_W-1:0] fifo_level,
  output logic [NUM_SUBCHANNELS-1:0]       arb_grant,
  output logic                             mode_ganged,
  output logic                             mode_switching,
  input  logic                             err_clr,
  output logic                             error_status,
  output logic [ERR_CNT_WIDTH-1:0]         err_count
);
  localparam int N     = NUM_SUBCHANNELS;
  localparam int SW    = SUBCHANNEL_WIDTH;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int IDX_W = $clog2(NUM_SUBCHANNELS);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

  typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} state_t;
  state_t state, state_nxt;

  logic [SW-1:0]    mem    [N][FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr [N];
  logic [PTR_W-1:0] rd_ptr [N];
  logic [LVL_W-1:0] level  [N];
  logic [N-1:0]     full, empty, eligible, push, pop;
  logic             all_empty, any_full, err_evt, found_hi;
  logic [IDX_W-1:0] last, grant_idx, hi_idx, lo_idx;

  always_comb begin
    full           = '0;
    empty          = '0;
    eligible       = '0;
    pop            = '0;
    subch_valid    = '0;
    subch_data_out = '0;
    fifo_level     = '0;
    for (int i = 0; i < N; i++) begin
      full[i]        = (level[i] == FULL_LVL);
      empty[i]       = (level[i] == '0);
      eligible[i]    = cfg_subchannel_en[i] && !full[i];
      subch_valid[i] = !empty[i];
      pop[i]         = !empty[i] && subch_ready[i];
      fifo_level[i*LVL_W +: LVL_W] = level[i];
      // Head is masked while empty so stale storage never leaks onto the bus.
      if (!empty[i]) subch_data_out[i*SW +: SW] = mem[i][rd_ptr[i]];
    end
  end

  assign all_empty      = &empty;
  assign any_full       = |full;
  assign mode_switching = (state == DRAIN);

  // Round-robin: lowest eligible index above last wins, else wrap to lowest eligible overall.
  always_comb begin
    hi_idx   = '0;
    lo_idx   = '0;
    found_hi = 1'b0;
    for (int i = N-1; i >= 0; i--) begin
      if (eligible[i]) begin
        if (i > int'(last)) begin
          hi_idx   = IDX_W'(i);
          found_hi = 1'b1;
        end
        lo_idx = IDX_W'(i);
      end
    end
    grant_idx = found_hi ? hi_idx : lo_idx;
  end

  always_comb begin
    state_nxt     = state;
    data_in_ready = 1'b0;
    push          = '0;
    err_evt       = 1'b0;
    case (state)
      DRAIN: if (all_empty) state_nxt = RUN;
      RUN: begin
        if (cfg_ganged != mode_ganged) begin
          state_nxt = DRAIN;
        end else if (!mode_ganged) begin
          if (cfg_subchannel_en == '0) begin
            data_in_ready = 1'b1;
            err_evt       = data_in_valid;
          end else begin
            data_in_ready = |eligible;
            if (data_in_valid && |eligible) push[grant_idx] = 1'b1;
          end
        end else begin
          if (!(&cfg_subchannel_en)) begin
            data_in_ready = 1'b1;
            err_evt       = data_in_valid;
          end else begin
            data_in_ready = !any_full;
            if (data_in_valid && !any_full) push = '1;
          end
        end
      end
      default: state_nxt = DRAIN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= DRAIN;
      mode_ganged  <= 1'b0;
      last         <= IDX_W'(N-1);
      arb_grant    <= '0;
      error_status <= 1'b0;
      err_count    <= '0;
      for (int i = 0; i < N; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        level[i]  <= '0;
      end
    end else begin
      state <= state_nxt;
      if (state == DRAIN && all_empty) mode_ganged <= cfg_ganged;
      if (!mode_ganged && |push) begin
        arb_grant <= push;
        last      <= grant_idx;
      end
      for (int i = 0; i < N; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
        case ({push[i], pop[i]})
          2'b10:   level[i] <= level[i] + LVL_W'(1);
          2'b01:   level[i] <= level[i] - LVL_W'(1);
          default: level[i] <= level[i];
        endcase
      end
      // A fresh error arriving with the clear counts as the first error after it.
      if (err_clr) begin
        error_status <= err_evt;
        err_count    <= err_evt ? ERR_CNT_WIDTH'(1) : '0;
      end else if (err_evt) begin
        error_status <= 1'b1;
        if (err_count != '1) err_count <= err_count + ERR_CNT_WIDTH'(1);
      end
    end
  end

  // FIFO storage is data-only and carries no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (push[i]) mem[i][wr_ptr[i]] <= mode_ganged ? data_in[i*SW +: SW] : data_in[SW-1:0];
    end
  end
endmodule

// File: tb/tb_subchannel_router_fifo.sv
// Directed bench for subchannel_router_fifo: N=2, 40-bit slices, depth 8, 2-bit error counter.
module tb_subchannel_router_fifo;
  localparam int N = 2, SW = 40, D = 8, EW = 2, DW = N*SW, LW = 4;

  logic          clk = 1'b0;
  logic          rst, cfg_ganged, data_in_valid, data_in_ready, err_clr;
  logic          mode_ganged, mode_switching, error_status;
  logic [N-1:0]  cfg_subchannel_en, subch_valid, subch_ready, arb_grant;
  logic [DW-1:0] data_in, subch_data_out;
  logic [N*LW-1:0] fifo_level;
  logic [EW-1:0] err_count;
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  subchannel_router_fifo #(.NUM_SUBCHANNELS(N), .SUBCHANNEL_WIDTH(SW), .FIFO_DEPTH(D),
                           .ERR_CNT_WIDTH(EW)) dut (
    .clk(clk), .rst(rst), .cfg_ganged(cfg_ganged), .cfg_subchannel_en(cfg_subchannel_en),
    .data_in(data_in), .data_in_valid(data_in_valid), .data_in_ready(data_in_ready),
    .subch_data_out(subch_data_out), .subch_valid(subch_valid), .subch_ready(subch_ready),
    .fifo_level(fifo_level), .arb_grant(arb_grant), .mode_ganged(mode_ganged),
    .mode_switching(mode_switching), .err_clr(err_clr), .error_status(error_status),
    .err_count(err_count));

  function automatic logic [LW-1:0] lvl(input int i);
    return fifo_level[i*LW +: LW];
  endfunction

  function automatic logic [SW-1:0] head(input int i);
    return subch_data_out[i*SW +: SW];
  endfunction

  task automatic cyc;
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input logic g);
    rst = 1'b1; cfg_ganged = g; cfg_subchannel_en = '0; data_in = '0; data_in_valid = 1'b0;
    subch_ready = '0; err_clr = 1'b0;
    cyc; cyc;
    rst = 1'b0;
    cyc;
  endtask

  task automatic test_reset;
    rst = 1'b1; cfg_ganged = 1'b0; cfg_subchannel_en = 2'b11; data_in = '0; data_in_valid = 1'b0;
    subch_ready = '0; err_clr = 1'b0;
    cyc; cyc;
    n_cmp++; if (fifo_level !== '0) begin n_err++; $display("FAIL rst_level got=%0h exp=0", fifo_level); end
    n_cmp++; if (subch_valid !== '0) begin n_err++; $display("FAIL rst_valid got=%0b exp=0", subch_valid); end
    n_cmp++; if (subch_data_out !== '0) begin n_err++; $display("FAIL rst_data got=%0h exp=0", subch_data_out); end
    n_cmp++; if (data_in_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready got=%0b exp=0", data_in_ready); end
    n_cmp++; if (arb_grant !== '0) begin n_err++; $display("FAIL rst_grant got=%0b exp=0", arb_grant); end
    n_cmp++; if (mode_ganged !== 1'b0) begin n_err++; $display("FAIL rst_mode got=%0b exp=0", mode_ganged); end
    n_cmp++; if (mode_switching !== 1'b1) begin n_err++; $display("FAIL rst_drain got=%0b exp=1", mode_switching); end
    n_cmp++; if ({error_status, err_count} !== '0) begin n_err++; $display("FAIL rst_err got=%0b/%0d exp=0/0", error_status, err_count); end
    rst = 1'b0; #2;
    n_cmp++; if (data_in_ready !== 1'b0) begin n_err++; $display("FAIL post_rst_ready got=%0b exp=0", data_in_ready); end
    n_cmp++; if (mode_switching !== 1'b1) begin n_err++; $display("FAIL post_rst_drain got=%0b exp=1", mode_switching); end
    cyc;
    n_cmp++; if (data_in_ready !== 1'b1) begin n_err++; $display("FAIL run_ready got=%0b exp=1", data_in_ready); end
    n_cmp++; if (mode_switching !== 1'b0) begin n_err++; $display("FAIL run_state got=%0b exp=0", mode_switching); end
  endtask

  task automatic test_indep_rr;
    do_reset(1'b0);
    cfg_subchannel_en = 2'b11;
    for (int k = 0; k < 4; k++) begin
      data_in = DW'(8'hA1 + k); data_in_valid = 1'b1; #2;
      n_cmp++; if (data_in_ready !== 1'b1) begin n_err++; $display("FAIL rr_ready%0d got=%0b exp=1", k, data_in_ready); end
      if (k == 0) begin
        n_cmp++; if (subch_valid !== 2'b00) begin n_err++; $display("FAIL rr_no_bypass got=%0b exp=00", subch_valid); end
      end
      cyc;
      n_cmp++; if (arb_grant !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin n_err++; $display("FAIL rr_grant%0d got=%0b exp=%0b", k, arb_grant, (k % 2 == 0) ? 2'b01 : 2'b10); end
      if (k == 0) begin
        n_cmp++; if (subch_valid !== 2'b01) begin n_err++; $display("FAIL rr_valid_t1 got=%0b exp=01", subch_valid); end
      end
    end
    data_in_valid = 1'b0; #2;
    n_cmp++; if ({lvl(1), lvl(0)} !== {4'd2, 4'd2}) begin n_err++; $display("FAIL rr_levels got=%0d/%0d exp=2/2", lvl(1), lvl(0)); end
    n_cmp++; if (head(0) !== 40'hA1) begin n_err++; $display("FAIL rr_head0 got=%0h exp=a1", head(0)); end
    n_cmp++; if (head(1) !== 40'hA2) begin n_err++; $display("FAIL rr_head1 got=%0h exp=a2", head(1)); end
    subch_ready = 2'b11;
    cyc;
    subch_ready = 2'b00;
    n_cmp++; if ({head(1), head(0)} !== {40'hA4, 40'hA3}) begin n_err++; $display("FAIL rr_pop_heads got=%0h/%0h exp=a4/a3", head(1), head(0)); end
    n_cmp++; if ({lvl(1), lvl(0)} !== {4'd1, 4'd1}) begin n_err++; $display("FAIL rr_pop_levels got=%0d/%0d exp=1/1", lvl(1), lvl(0)); end
  endtask

  task automatic test_full_backpressure;
    do_reset(1'b0);
    cfg_subchannel_en = 2'b01;
    for (int k = 0; k < 8; k++) begin
      data_in = DW'(8'hB1 + k); data_in_valid = 1'b1; #2;
      n_cmp++; if (data_in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready%0d got=%0b exp=1", k, data_in_ready); end
      cyc;
    end
    data_in = DW'(8'hB9); #2;
    n_cmp++; if (data_in_ready !== 1'b0) begin n_err++; $display("FAIL bp_full_ready got=%0b exp=0", data_in_ready); end
    n_cmp++; if ({lvl(1), lvl(0)} !== {4'd0, 4'd8}) begin n_err++; $display("FAIL bp_levels got=%0d/%0d exp=0/8", lvl(1), lvl(0)); end
    n_cmp++; if (error_status !== 1'b0) begin n_err++; $display("FAIL bp_no_error got=%0b exp=0", error_status); end
    subch_ready = 2'b01; #2;
    n_cmp++; if (data_in_ready !== 1'b0) begin n_err++; $display("FAIL bp_push_on_pop got=%0b exp=0", data_in_ready); end
    cyc;
    subch_ready = 2'b00; #2;
    n_cmp++; if (head(0) !== 40'hB2) begin n_err++; $display("FAIL bp_head got=%0h exp=b2", head(0)); end
    n_cmp++; if (lvl(0) !== 4'd7) begin n_err++; $display("FAIL bp_level7 got=%0d exp=7", lvl(0)); end
    n_cmp++; if (data_in_ready !== 1'b1) begin n_err++; $display("FAIL bp_reaccept got=%0b exp=1", data_in_ready); end
    cyc;
    data_in_valid = 1'b0; #2;
    n_cmp++; if (lvl(0) !== 4'd8) begin n_err++; $display("FAIL bp_refill got=%0d exp=8", lvl(0)); end
    n_cmp++; if (err_count !== 2'd0) begin n_err++; $display("FAIL bp_err_count got=%0d exp=0", err_count); end
  endtask

  task automatic test_ganged;
    do_reset(1'b1);
    n_cmp++; if (mode_ganged !== 1'b1) begin n_err++; $display("FAIL g_mode got=%0b exp=1", mode_ganged); end
    cfg_subchannel_en = 2'b11; subch_ready = 2'b11;
    data_in = {40'h2, 40'h1}; data_in_valid = 1'b1; #2;
    n_cmp++; if (data_in_ready !== 1'b1) begin n_err++; $display("FAIL g_ready got=%0b exp=1", data_in_ready); end
    cyc;
    data_in_valid = 1'b0; #2;
    n_cmp++; if (subch_valid !== 2'b11) begin n_err++; $display("FAIL g_valid got=%0b exp=11", subch_valid); end
    n_cmp++; if ({head(1), head(0)} !== {40'h2, 40'h1}) begin n_err++; $display("FAIL g_heads got=%0h/%0h exp=2/1", head(1), head(0)); end
    n_cmp++; if (arb_grant !== 2'b00) begin n_err++; $display("FAIL g_grant got=%0b exp=00", arb_grant); end
    cyc;
    n_cmp++; if (fifo_level !== '0) begin n_err++; $display("FAIL g_drained got=%0h exp=0", fifo_level); end
    subch_ready = 2'b00;
  endtask

  task automatic test_mode_switch;
    do_reset(1'b0);
    cfg_subchannel_en = 2'b10;
    for (int k = 0; k < 3; k++) begin
      data_in = DW'(8'hC1 + k); data_in_valid = 1'b1;
      cyc;
    end
    data_in_valid = 1'b0; #2;
    n_cmp++; if ({lvl(1), lvl(0)} !== {4'd3, 4'd0}) begin n_err++; $display("FAIL ms_fill got=%0d/%0d exp=3/0", lvl(1), lvl(0)); end
    cfg_ganged = 1'b1; subch_ready = 2'b11; cfg_subchannel_en = 2'b11; #2;
    n_cmp++; if (data_in_ready !== 1'b0) begin n_err++; $display("FAIL ms_req_ready got=%0b exp=0", data_in_ready); end
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if (head(1) !== SW'(8'hC1 + k)) begin n_err++; $display("FAIL ms_head%0d got=%0h exp=%0h", k, head(1), 8'hC1 + k); end
      cyc;
      n_cmp++; if ({mode_switching, data_in_ready, mode_ganged} !== 3'b100) begin n_err++; $display("FAIL ms_drain%0d got=%0b exp=100", k, {mode_switching, data_in_ready, mode_ganged}); end
      n_cmp++; if (lvl(1) !== LW'(2 - k)) begin n_err++; $display("FAIL ms_level%0d got=%0d exp=%0d", k, lvl(1), 2 - k); end
    end
    cyc;
    n_cmp++; if ({mode_switching, mode_ganged} !== 2'b01) begin n_err++; $display("FAIL ms_done got=%0b exp=01", {mode_switching, mode_ganged}); end
    n_cmp++; if (data_in_ready !== 1'b1) begin n_err++; $display("FAIL ms_run_ready got=%0b exp=1", data_in_ready); end
    cfg_ganged = 1'b0; subch_ready = 2'b00;
  endtask

  task automatic test_error;
    do_reset(1'b0);
    data_in = DW'(40'hDEAD); data_in_valid = 1'b1; #2;
    n_cmp++; if (data_in_ready !== 1'b1) begin n_err++; $display("FAIL err_ready got=%0b exp=1", data_in_ready); end
    cyc;
    n_cmp++; if ({error_status, err_count} !== 3'b1_01) begin n_err++; $display("FAIL err_first got=%0b/%0d exp=1/1", error_status, err_count); end
    cyc;
    n_cmp++; if (err_count !== 2'd2) begin n_err++; $display("FAIL err_second got=%0d exp=2", err_count); end
    err_clr = 1'b1;
    cyc;
    err_clr = 1'b0; data_in_valid = 1'b0;
    n_cmp++; if ({error_status, err_count} !== 3'b1_01) begin n_err++; $display("FAIL err_clr_coincident got=%0b/%0d exp=1/1", error_status, err_count); end
    n_cmp++; if ({fifo_level, arb_grant} !== '0) begin n_err++; $display("FAIL err_dropped got=%0h/%0b exp=0/0", fifo_level, arb_grant); end
    err_clr = 1'b1;
    cyc;
    err_clr = 1'b0;
    n_cmp++; if ({error_status, err_count} !== 3'b0_00) begin n_err++; $display("FAIL err_clr got=%0b/%0d exp=0/0", error_status, err_count); end
  endtask

  task automatic test_saturate_and_reset;
    do_reset(1'b0);
    data_in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cyc;
      n_cmp++; if (err_count !== ((k < 3) ? 2'(k + 1) : 2'd3)) begin n_err++; $display("FAIL sat_count%0d got=%0d exp=%0d", k, err_count, (k < 3) ? k + 1 : 3); end
    end
    cfg_subchannel_en = 2'b11;
    for (int k = 0; k < 16; k++) begin
      data_in = DW'(k + 1);
      cyc;
    end
    #2;
    n_cmp++; if ({lvl(1), lvl(0)} !== {4'd8, 4'd8}) begin n_err++; $display("FAIL sat_full got=%0d/%0d exp=8/8", lvl(1), lvl(0)); end
    n_cmp++; if (data_in_ready !== 1'b0) begin n_err++; $display("FAIL sat_full_ready got=%0b exp=0", data_in_ready); end
    n_cmp++; if ({head(1), head(0)} !== {40'h2, 40'h1}) begin n_err++; $display("FAIL sat_heads got=%0h/%0h exp=2/1", head(1), head(0)); end
    rst = 1'b1;
    cyc;
    n_cmp++; if ({fifo_level, subch_valid} !== '0) begin n_err++; $display("FAIL mid_rst_fifo got=%0h/%0b exp=0/0", fifo_level, subch_valid); end
    n_cmp++; if (subch_data_out !== '0) begin n_err++; $display("FAIL mid_rst_data got=%0h exp=0", subch_data_out); end
    n_cmp++; if ({data_in_ready, arb_grant, error_status, err_count} !== '0) begin n_err++; $display("FAIL mid_rst_ctrl got=%0b exp=0", {data_in_ready, arb_grant, error_status, err_count}); end
    n_cmp++; if (mode_switching !== 1'b1) begin n_err++; $display("FAIL mid_rst_drain got=%0b exp=1", mode_switching); end
    rst = 1'b0; data_in_valid = 1'b0;
    cyc;
  endtask

  initial begin
    test_reset();
    test_indep_rr();
    test_full_backpressure();
    test_ganged();
    test_mode_switch();
    test_error();
    test_saturate_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/subchannel_router_fifo.md
Name: subchannel_router_fifo

Overview:
Parametrised successor to the DDR5 RCD subchannel controller. It routes an incoming data stream into N per-subchannel FIFOs and drains each FIFO through a valid/ready output handshake.
- Independent mode: one slice per input beat, distributed by round-robin over eligible subchannels.
- Ganged mode: one full-width beat split across all subchannels.
- Also provides a drain-before-mode-switch FSM, backpressure, FIFO level reporting, and sticky error plus a saturating error counter.
- Sits between the host-side data path and the per-subchannel output drivers.

Parameters:
- NUM_SUBCHANNELS, 2, number of subchannels (>=2).
- SUBCHANNEL_WIDTH, 40, bits per subchannel slice.
- FIFO_DEPTH, 8, entries per subchannel FIFO (power of 2, >=2).
- ERR_CNT_WIDTH, 8, width of the saturating error counter.
- Derived: DATA_WIDTH = NUM_SUBCHANNELS*SUBCHANNEL_WIDTH; LVL_W = $clog2(FIFO_DEPTH+1).

Ports:
- clk  in  1  Single clock. One clock; reset is synchronous and active-high.
- rst  in  1  Synchronous active-high reset.
- cfg_ganged  in  1  1 = ganged mode, 0 = independent mode; applied only via the mode FSM.
- cfg_subchannel_en  in  NUM_SUBCHANNELS  Per-subchannel enable.
- data_in  in  DATA_WIDTH  Input beat; independent mode uses bits [SUBCHANNEL_WIDTH-1:0] only.
- data_in_valid  in  1  Input beat valid.
- data_in_ready  out  1  Input accept; a beat transfers when valid&&ready.
- subch_data_out  out  DATA_WIDTH  FIFO heads, slice i = [i*SUBCHANNEL_WIDTH +: SUBCHANNEL_WIDTH].
- subch_valid  out  NUM_SUBCHANNELS  Per-subchannel FIFO non-empty.
- subch_ready  in  NUM_SUBCHANNELS  Per-subchannel pop; a pop occurs when valid&&ready.
- fifo_level  out  NUM_SUBCHANNELS*LVL_W  Per-FIFO occupancy, 0..FIFO_DEPTH.
- arb_grant  out  NUM_SUBCHANNELS  One-hot, registered; the subchannel that received the last independent-mode push.
- mode_ganged  out  1  Active (latched) mode.
- mode_switching  out  1  High while in DRAIN.
- err_clr  in  1  Clears error_status and err_count.
- error_status  out  1  Sticky error flag.
- err_count  out  ERR_CNT_WIDTH  Saturating error count.

Behaviour:
- Reset values (while rst=1, and on the cycle after it deasserts):
  - All FIFOs empty; fifo_level=0; subch_valid=0; subch_data_out=0.
  - data_in_ready=0; arb_grant=0; mode_ganged=0; FSM in DRAIN; rr pointer last=NUM_SUBCHANNELS-1.
  - error_status=0; err_count=0.
  - Reset mid-operation discards all FIFO contents.
- Mode FSM, states RUN and DRAIN:
  - DRAIN: data_in_ready=0. When all FIFOs are empty, latch mode_ganged<=cfg_ganged and go to RUN on the next cycle.
  - RUN: if cfg_ganged != mode_ganged, go to DRAIN (no push that cycle). Otherwise route.
  - Pops continue in both states.
- Independent routing (RUN, mode_ganged=0):
  - eligible[i] = cfg_subchannel_en[i] && level[i] < FIFO_DEPTH.
  - Grant the first eligible i searching from last+1 modulo N.
  - data_in_ready = |eligible. On transfer, push data_in[SW-1:0] into FIFO i, arb_grant<=onehot(i), last<=i.
- Ganged routing (RUN, mode_ganged=1):
  - data_in_ready = (&cfg_subchannel_en) && no FIFO full.
  - On transfer, slice i is pushed into FIFO i in the same cycle; arb_grant unchanged.
- Full FIFO is not eligible even if popped in the same cycle (no push-on-pop-when-full).
- Simultaneous push and pop on a non-full, non-empty FIFO: level unchanged, order preserved.
- Latency: a beat pushed in cycle T is visible at subch_data_out with subch_valid=1 in T+1. There is no bypass.
- Output head is show-ahead and stable while valid && !ready.
- A disabled subchannel stops receiving pushes but still drains existing entries.
- Error/drop (RUN, data_in_valid=1): data_in_ready=1, the beat is dropped and an error event is raised when either:
  - independent mode with cfg_subchannel_en==0, or
  - ganged mode with any enable bit clear.
- Backpressure caused by full FIFOs is never an error.
- Error counting:
  - An error event sets error_status and increments err_count, saturating at 2^ERR_CNT_WIDTH-1.
  - err_clr zeroes both.
  - Error event coincident with err_clr gives error_status=1, err_count=1.
- FIFO pointers wrap modulo FIFO_DEPTH; level is tracked explicitly.

Test Plan:
1. Reset, N=2, independent, both enabled, subch_ready=0, push beats 0xA1..0xA4 → FIFO0 gets A1,A3; FIFO1 gets A2,A4; arb_grant sequence 01,10,01,10; levels 2/2; subch_valid rises one cycle after the first push.
2. Independent, en=2'b01, subch_ready=0, push 9 beats with DEPTH=8 → beats 1-8 go to FIFO0; data_in_ready=0 on beat 9; no error; one pop then re-accepts beat 9 next cycle.
3. Ganged, en=2'b11, data_in={40'h2,40'h1}, subch_ready=2'b11 continuously → slice 1 out of subch0 and 2 out of subch1 at T+1; levels return to 0.
4. Toggle cfg_ganged 0→1 with 3 entries in FIFO1, subch_ready=1 → mode_switching=1, data_in_ready=0 until FIFO1 empties (3 pops); mode_ganged=1 the following cycle; then RUN.
5. Independent, en=0, 3 valid beats, err_clr pulsed together with the 3rd → beats dropped with ready=1; err_count 1,2 then 1; error_status stays 1.
6. ERR_CNT_WIDTH=2, 5 error beats → err_count saturates at 3; assert rst mid-stream with full FIFOs → all levels 0 and outputs reset next cycle.
